// File: rtl/race_menu_pkg.sv
// race_menu_pkg: types and helpers shared by the race menu screen and its LED locator.
//   state_e   - countdown FSM encoding (idle / counting / done)
//   rgb_t     - one LED colour, 8 bits per component
//   max_pos() - LED count of a triangle layout
//   row_base()- first LED index of a triangle row
//   palette() - per-player ready-bar colour
package race_menu_pkg;

    localparam int unsigned RowW    = 4;  // rows 0..14
    localparam int unsigned PlayerW = 3;  // players 0..7

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    function automatic int unsigned max_pos(int unsigned players, int unsigned rows);
        return players * ((rows * (rows + 1)) / 2 - 1) + 1;
    endfunction

    // Rows before r hold one segment per player, each NUM_ROWS-k LEDs long.
    function automatic int unsigned row_base(int unsigned players, int unsigned rows,
                                             int unsigned r);
        int unsigned base;
        base = 0;
        for (int unsigned k = 0; k < r; k++) begin
            base += players * (rows - k);
        end
        return base;
    endfunction

    function automatic rgb_t palette(logic [PlayerW-1:0] p, logic [7:0] lvl);
        logic [7:0] half;
        rgb_t       c;
        half = lvl >> 1;
        case (p)
            3'd0:    c = '{red: lvl,   green: 8'd0,  blue: 8'd0};
            3'd1:    c = '{red: 8'd0,  green: lvl,   blue: 8'd0};
            3'd2:    c = '{red: 8'd0,  green: 8'd0,  blue: lvl};
            3'd3:    c = '{red: lvl,   green: lvl,   blue: 8'd0};
            3'd4:    c = '{red: 8'd0,  green: lvl,   blue: lvl};
            3'd5:    c = '{red: lvl,   green: 8'd0,  blue: lvl};
            3'd6:    c = '{red: lvl,   green: half,  blue: 8'd0};
            default: c = '{red: half,  green: half,  blue: half};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/race_menu_screen_if.sv
// race_menu_screen_if: LED intensity bus of one screen-chain stage.
//   led_number      - LED index being rendered (LED_W = $clog2(MAX_POS))
//   i_*_intensity   - colour arriving from the upstream stage
//   o_*_intensity   - colour passed to the downstream stage
// master drives the index and upstream colour; slave is the screen stage.
interface race_menu_screen_if #(
    parameter int unsigned LED_W = 7
);
    logic [LED_W-1:0] led_number;
    logic [7:0]       i_red_intensity;
    logic [7:0]       i_blue_intensity;
    logic [7:0]       i_green_intensity;
    logic [7:0]       o_red_intensity;
    logic [7:0]       o_blue_intensity;
    logic [7:0]       o_green_intensity;

    modport master (
        output led_number, i_red_intensity, i_blue_intensity, i_green_intensity,
        input  o_red_intensity, o_blue_intensity, o_green_intensity
    );

    modport slave (
        input  led_number, i_red_intensity, i_blue_intensity, i_green_intensity,
        output o_red_intensity, o_blue_intensity, o_green_intensity
    );
endinterface

// File: rtl/race_menu_locator.sv
// race_menu_locator: combinational map from LED index to triangle-layout position.
//   i_led_number - LED index
//   o_valid      - index lies inside the layout (< MAX_POS)
//   o_row        - triangle row, NUM_ROWS-1 is the single apex LED
//   o_player     - segment (player lane) within the row
//   o_is_marker  - first LED of a segment, or the apex
module race_menu_locator
    import race_menu_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned NUM_ROWS    = 7,
    parameter int unsigned LED_W       = 7
) (
    input  logic [LED_W-1:0]   i_led_number,
    output logic               o_valid,
    output logic [RowW-1:0]    o_row,
    output logic [PlayerW-1:0] o_player,
    output logic               o_is_marker
);
    localparam int unsigned MaxPos = max_pos(NUM_PLAYERS, NUM_ROWS);

    logic [NUM_ROWS-1:0] w_hit;
    logic [NUM_ROWS-1:0] w_marker;
    logic [PlayerW-1:0]  w_player [NUM_ROWS];

    for (genvar r = 0; r < NUM_ROWS - 1; r++) begin : g_row
        localparam int unsigned Base   = row_base(NUM_PLAYERS, NUM_ROWS, r);
        localparam int unsigned SegLen = NUM_ROWS - r;
        localparam int unsigned Size   = NUM_PLAYERS * SegLen;
        logic [31:0] w_off;

        // Indices below Base wrap to huge offsets, so one compare bounds both ends.
        assign w_off       = 32'(i_led_number) - Base;
        assign w_hit[r]    = w_off < Size;
        assign w_player[r] = PlayerW'(w_off / SegLen);
        assign w_marker[r] = (w_off % SegLen) == 0;
    end

    assign w_hit[NUM_ROWS-1]    = 32'(i_led_number) == MaxPos - 1;
    assign w_player[NUM_ROWS-1] = '0;
    assign w_marker[NUM_ROWS-1] = 1'b1;

    // Row ranges are disjoint, so at most one hit is set.
    always_comb begin
        o_valid     = 1'b0;
        o_row       = '0;
        o_player    = '0;
        o_is_marker = 1'b0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (w_hit[r]) begin
                o_valid     = 1'b1;
                o_row       = RowW'(r);
                o_player    = w_player[r];
                o_is_marker = w_marker[r];
            end
        end
    end

endmodule

// File: rtl/race_menu_screen.sv
// race_menu_screen: race start menu with ready flags and a start countdown.
//   clk, reset    - clock, asynchronous active-high reset
//   enable        - screen selected: bus outputs carry this screen, else pass upstream
//   step_tick     - time-base strobe; STEP_TICKS of them per countdown step
//   start, clear  - countdown request / clear ready flags and abort
//   ready_in      - per-player ready pulses (latched in idle)
//   bus           - LED index in, upstream colour in, downstream colour out
//   ready_o, countdown_o, busy, go - status; go pulses as the countdown hits 0
// Optional: define RACE_MENU_BLINK_EN to blink the next marker row to go dark.
module race_menu_screen
    import race_menu_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned NUM_ROWS    = 7,
    parameter int unsigned STEP_TICKS  = 50,
    parameter int unsigned INTENSITY   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         step_tick,
    input  logic                         start,
    input  logic                         clear,
    input  logic [NUM_PLAYERS-1:0]       ready_in,
    race_menu_screen_if.slave            bus,
    output logic [NUM_PLAYERS-1:0]       ready_o,
    output logic [$clog2(NUM_ROWS+1)-1:0] countdown_o,
    output logic                         busy,
    output logic                         go
);
    localparam int unsigned MAX_POS = max_pos(NUM_PLAYERS, NUM_ROWS);
    localparam int unsigned LedW    = $clog2(MAX_POS);
    localparam int unsigned CdW     = $clog2(NUM_ROWS + 1);
    localparam int unsigned StepW   = $clog2(STEP_TICKS + 1);
    localparam logic [7:0]  Lvl     = 8'(INTENSITY);

    state_e                 r_state;
    logic [NUM_PLAYERS-1:0] r_ready;
    logic [CdW-1:0]         r_countdown;
    logic [StepW-1:0]       r_step;
    logic                   r_busy;
    logic                   r_go;
    rgb_t                   r_colour;

    logic                   w_valid;
    logic [RowW-1:0]        w_row;
    logic [PlayerW-1:0]     w_player;
    logic                   w_is_marker;
    logic [7:0]             w_ready8;
    logic                   w_lit;
    int unsigned            w_thresh;
    rgb_t                   w_colour;

    race_menu_locator #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .NUM_ROWS    (NUM_ROWS),
        .LED_W       (LedW)
    ) u_locator (
        .i_led_number (bus.led_number),
        .o_valid      (w_valid),
        .o_row        (w_row),
        .o_player     (w_player),
        .o_is_marker  (w_is_marker)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_ready     <= '0;
            r_countdown <= '0;
            r_step      <= '0;
            r_busy      <= 1'b0;
            r_go        <= 1'b0;
        end else begin
            r_go <= 1'b0;
            if (clear) begin
                r_state     <= StIdle;
                r_ready     <= '0;
                r_countdown <= '0;
                r_step      <= '0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_ready <= r_ready | ready_in;
                        if (start && |r_ready) begin
                            r_state     <= StCount;
                            r_countdown <= CdW'(NUM_ROWS);
                            r_step      <= '0;
                            r_busy      <= 1'b1;
                        end
                    end
                    StCount: begin
                        if (step_tick) begin
                            if (r_step == StepW'(STEP_TICKS - 1)) begin
                                r_step      <= '0;
                                r_countdown <= r_countdown - CdW'(1);
                                if (r_countdown == CdW'(1)) begin
                                    r_go    <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= StDone;
                                end
                            end else begin
                                r_step <= r_step + StepW'(1);
                            end
                        end
                    end
                    default: ;  // StDone holds until clear
                endcase
            end
        end
    end

    // Colour of the LED being presented; marker threshold wins over the ready bar.
    always_comb begin
        w_colour = '0;
        w_ready8 = 8'(r_ready);
        w_thresh = NUM_ROWS - 32'(w_row);
        w_lit    = 32'(r_countdown) >= w_thresh;
`ifdef RACE_MENU_BLINK_EN
        if (r_state == StCount && 32'(r_countdown) == w_thresh &&
            !(32'(r_step) < STEP_TICKS / 2)) begin
            w_lit = 1'b0;
        end
`endif
        if (w_valid) begin
            if (w_is_marker) begin
                if (w_lit) begin
                    w_colour = '{red: Lvl, green: Lvl, blue: Lvl};
                end
            end else if (w_ready8[w_player]) begin
                w_colour = palette(w_player, Lvl);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_colour <= '0;
        end else begin
            r_colour <= w_colour;
        end
    end

    assign bus.o_red_intensity   = enable ? r_colour.red   : bus.i_red_intensity;
    assign bus.o_green_intensity = enable ? r_colour.green : bus.i_green_intensity;
    assign bus.o_blue_intensity  = enable ? r_colour.blue  : bus.i_blue_intensity;

    assign ready_o     = r_ready;
    assign countdown_o = r_countdown;
    assign busy        = r_busy;
    assign go          = r_go;

endmodule

// File: tb/tb_race_menu_screen.sv
// tb_race_menu_screen: self-checking bench for race_menu_screen.
// dut0: 4 players, 7 rows, STEP_TICKS=2 (MAX_POS=109).
// dut1: 2 players, 3 rows, STEP_TICKS=4 (MAX_POS=11).
// A bench model tracks state; expected colours are queued when an LED index is
// driven and compared against the bus one clock later.
module tb_race_menu_screen;

    localparam int unsigned INT = 5;
    localparam int unsigned LW0 = 7;  // $clog2(109)
    localparam int unsigned LW1 = 4;  // $clog2(11)
    localparam int M_IDLE = 0, M_COUNT = 1, M_DONE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       en0, tick0, start0, clear0;
    logic [3:0] rin0, rdy0;
    logic [2:0] cd0;
    logic       busy0, go0;
    logic       en1, tick1, start1, clear1;
    logic [1:0] rin1, rdy1;
    logic [1:0] cd1;
    logic       busy1, go1;

    race_menu_screen_if #(.LED_W(LW0)) bus0 ();
    race_menu_screen_if #(.LED_W(LW1)) bus1 ();

    race_menu_screen #(
        .NUM_PLAYERS (4), .NUM_ROWS (7), .STEP_TICKS (2), .INTENSITY (INT)
    ) dut0 (
        .clk (clk), .reset (reset), .enable (en0), .step_tick (tick0), .start (start0),
        .clear (clear0), .ready_in (rin0), .bus (bus0), .ready_o (rdy0),
        .countdown_o (cd0), .busy (busy0), .go (go0)
    );

    race_menu_screen #(
        .NUM_PLAYERS (2), .NUM_ROWS (3), .STEP_TICKS (4), .INTENSITY (INT)
    ) dut1 (
        .clk (clk), .reset (reset), .enable (en1), .step_tick (tick1), .start (start1),
        .clear (clear1), .ready_in (rin1), .bus (bus1), .ready_o (rdy1),
        .countdown_o (cd1), .busy (busy1), .go (go1)
    );

    typedef struct {
        string       tag;
        logic [23:0] exp;
    } sb_t;

    sb_t        sbq[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_go0 = 0;
    int         n_go1 = 0;
    int         m_state [2];
    int         m_cd [2];
    int         m_step [2];
    logic [7:0] m_ready [2];
    logic       m_go [2];

    function automatic int np_of(int d); return (d == 0) ? 4 : 2; endfunction
    function automatic int nr_of(int d); return (d == 0) ? 7 : 3; endfunction
    function automatic int st_of(int d); return (d == 0) ? 2 : 4; endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pal(int p);
        logic [7:0] i, h;
        i = 8'(INT);
        h = 8'(INT / 2);
        case (p)
            0:       return {i, 8'd0, 8'd0};
            1:       return {8'd0, i, 8'd0};
            2:       return {8'd0, 8'd0, i};
            3:       return {i, i, 8'd0};
            4:       return {8'd0, i, i};
            5:       return {i, 8'd0, i};
            6:       return {i, h, 8'd0};
            default: return {h, h, h};
        endcase
    endfunction

    // Expected {red, green, blue} for an LED given the model state before the edge.
    function automatic logic [23:0] exp_col(int d, int led);
        int  np, nr, maxpos, base, row, off, seglen;
        bit  lit;
        np     = np_of(d);
        nr     = nr_of(d);
        maxpos = np * ((nr * (nr + 1)) / 2 - 1) + 1;
        if (led >= maxpos) return 24'd0;
        base   = 0;
        row    = nr - 1;
        off    = 0;
        seglen = 1;
        for (int r = 0; r < nr - 1; r++) begin
            if (row == nr - 1 && led >= base && led < base + np * (nr - r)) begin
                row    = r;
                off    = led - base;
                seglen = nr - r;
            end
            base += np * (nr - r);
        end
        if (off % seglen == 0) begin
            lit = m_cd[d] >= nr - row;
`ifdef RACE_MENU_BLINK_EN
            if (m_state[d] == M_COUNT && m_cd[d] == nr - row && !(m_step[d] < st_of(d) / 2))
                lit = 1'b0;
`endif
            return lit ? {8'(INT), 8'(INT), 8'(INT)} : 24'd0;
        end
        return m_ready[d][off / seglen] ? pal(off / seglen) : 24'd0;
    endfunction

    task automatic model_reset(input int d);
        m_state[d] = M_IDLE;
        m_cd[d]    = 0;
        m_step[d]  = 0;
        m_ready[d] = 8'd0;
        m_go[d]    = 1'b0;
    endtask

    task automatic model_step(input int d, input logic st, input logic cl, input logic tk,
                              input logic [7:0] rin);
        m_go[d] = 1'b0;
        if (cl) begin
            model_reset(d);
        end else if (m_state[d] == M_IDLE) begin
            if (st && m_ready[d] != 0) begin
                m_state[d] = M_COUNT;
                m_cd[d]    = nr_of(d);
                m_step[d]  = 0;
            end
            m_ready[d] = m_ready[d] | rin;
        end else if (m_state[d] == M_COUNT && tk) begin
            if (m_step[d] == st_of(d) - 1) begin
                m_step[d] = 0;
                m_cd[d]--;
                if (m_cd[d] == 0) begin
                    m_go[d]    = 1'b1;
                    m_state[d] = M_DONE;
                end
            end else begin
                m_step[d]++;
            end
        end
    endtask

    task automatic cycle();
        sb_t e;
        e.tag = "col0";
        e.exp = exp_col(0, int'(bus0.led_number));
        sbq.push_back(e);
        e.tag = "col1";
        e.exp = exp_col(1, int'(bus1.led_number));
        sbq.push_back(e);
        @(posedge clk);
        model_step(0, start0, clear0, tick0, 8'(rin0));
        model_step(1, start1, clear1, tick1, 8'(rin1));
        #1;
        e = sbq.pop_front();
        check_eq(e.tag, 32'({bus0.o_red_intensity, bus0.o_green_intensity,
                             bus0.o_blue_intensity}),
                 32'(en0 ? e.exp : {bus0.i_red_intensity, bus0.i_green_intensity,
                                    bus0.i_blue_intensity}));
        e = sbq.pop_front();
        check_eq(e.tag, 32'({bus1.o_red_intensity, bus1.o_green_intensity,
                             bus1.o_blue_intensity}),
                 32'(en1 ? e.exp : {bus1.i_red_intensity, bus1.i_green_intensity,
                                    bus1.i_blue_intensity}));
        check_eq("ready0", 32'(rdy0), 32'(m_ready[0]));
        check_eq("cd0", 32'(cd0), 32'(m_cd[0]));
        check_eq("busy0", 32'(busy0), 32'(m_state[0] == M_COUNT));
        check_eq("go0", 32'(go0), 32'(m_go[0]));
        check_eq("ready1", 32'(rdy1), 32'(m_ready[1]));
        check_eq("cd1", 32'(cd1), 32'(m_cd[1]));
        check_eq("busy1", 32'(busy1), 32'(m_state[1] == M_COUNT));
        check_eq("go1", 32'(go1), 32'(m_go[1]));
        if (go0) n_go0++;
        if (go1) n_go1++;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_cd0"}, 32'(cd0), 32'd0);
        check_eq({tag, "_busy0"}, 32'(busy0), 32'd0);
        check_eq({tag, "_go0"}, 32'(go0), 32'd0);
        check_eq({tag, "_ready0"}, 32'(rdy0), 32'd0);
        check_eq({tag, "_col0"}, 32'({bus0.o_red_intensity, bus0.o_green_intensity,
                                      bus0.o_blue_intensity}), 32'd0);
        check_eq({tag, "_cd1"}, 32'(cd1), 32'd0);
        check_eq({tag, "_ready1"}, 32'(rdy1), 32'd0);
        check_eq({tag, "_col1"}, 32'({bus1.o_red_intensity, bus1.o_green_intensity,
                                      bus1.o_blue_intensity}), 32'd0);
    endtask

    int leds0 [8] = '{1, 15, 8, 0, 127, 109, 7, 14};
    int leds1 [4] = '{0, 3, 10, 1};

    initial begin
        en0 = 1'b1; tick0 = 1'b0; start0 = 1'b0; clear0 = 1'b0; rin0 = '0;
        en1 = 1'b1; tick1 = 1'b0; start1 = 1'b0; clear1 = 1'b0; rin1 = '0;
        bus0.led_number = '0;
        bus0.i_red_intensity = 8'h0; bus0.i_green_intensity = 8'h0;
        bus0.i_blue_intensity = 8'h0;
        bus1.led_number = '0;
        bus1.i_red_intensity = 8'h0; bus1.i_green_intensity = 8'h0;
        bus1.i_blue_intensity = 8'h0;
        model_reset(0);
        model_reset(1);

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        // start with no ready flags must not leave idle
        start0 = 1'b1;
        cycle();
        cycle();
        start0 = 1'b0;

        // latch ready flags, then walk the layout
        rin0 = 4'b0101;
        rin1 = 2'b11;
        cycle();
        rin0 = '0;
        rin1 = '0;
        for (int i = 0; i < 11; i++) begin
            bus0.led_number = LW0'(leds0[i % 8]);
            bus1.led_number = LW1'(i);
            cycle();
        end

        // disabled screen passes the upstream bus through without a clock
        en0 = 1'b0;
        bus0.i_red_intensity = 8'h11;
        bus0.i_blue_intensity = 8'h22;
        bus0.i_green_intensity = 8'h33;
        #1;
        check_eq("pt_red", 32'(bus0.o_red_intensity), 32'h11);
        check_eq("pt_blue", 32'(bus0.o_blue_intensity), 32'h22);
        check_eq("pt_green", 32'(bus0.o_green_intensity), 32'h33);
        cycle();
        en0 = 1'b1;

        // clear beats a same-cycle ready pulse
        clear0 = 1'b1;
        rin0 = 4'b0001;
        cycle();
        clear0 = 1'b0;
        cycle();
        rin0 = '0;

        // full countdown on both screens, tick every cycle
        n_go0 = 0;
        n_go1 = 0;
        start0 = 1'b1; tick0 = 1'b1;
        start1 = 1'b1; tick1 = 1'b1;
        cycle();
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus0.led_number = (i % 2 == 1) ? LW0'(108) : LW0'(0);
            bus1.led_number = LW1'(leds1[i % 4]);
            cycle();
        end
        check_eq("go_once0", 32'(n_go0), 32'd1);
        check_eq("go_once1", 32'(n_go1), 32'd1);

        // clear mid-count together with a step tick
        tick0 = 1'b0;
        clear0 = 1'b1;
        cycle();
        clear0 = 1'b0;
        rin0 = 4'b0001;
        cycle();
        rin0 = '0;
        start0 = 1'b1;
        tick0 = 1'b1;
        cycle();
        start0 = 1'b0;
        n_go0 = 0;
        for (int i = 0; i < 40 && m_cd[0] != 4; i++) cycle();
        check_eq("cd_before_clear", 32'(cd0), 32'd4);
        clear0 = 1'b1;
        cycle();
        clear0 = 1'b0;
        tick0 = 1'b0;
        repeat (3) cycle();
        check_eq("go_after_clear", 32'(n_go0), 32'd0);

        // asynchronous reset in the middle of a countdown
        rin0 = 4'b0010;
        cycle();
        rin0 = '0;
        start0 = 1'b1;
        tick0 = 1'b1;
        cycle();
        start0 = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset(0);
        model_reset(1);
        tick0 = 1'b0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
